// File: rtl/tpu_host_seq_if.sv
// Host-side byte streams of the TPU host sequencer.
//   s_valid/s_ready/s_data : host -> sequencer operand bytes (A0..A3, B0..B3)
//   m_valid/m_ready/m_data : sequencer -> host result bytes (c00, c01, c10, c11)
// master = the host, slave = the sequencer.
interface tpu_host_seq_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );
endinterface

// File: rtl/tpu_host_seq.sv
// Sequencer between a byte-stream host and a 2x2 matrix controller.
// Loads eight operand bytes (A0..A3, B0..B3), waits for the controller's done
// (bounded by TIMEOUT cycles), reads the four result bytes into a local buffer
// and streams them back to the host.
//   clk, rst_n   : clock, asynchronous active-low reset
//   host         : slave side of the host byte streams (s_* in, m_* out)
//   load_en, load_sel_ab, load_index, in_data : operand write port
//   done         : controller results available
//   output_en, output_sel, out_data           : result read port
//   busy         : anything in flight (not idle in LOAD)
//   err          : sticky done-timeout flag, cleared only by reset
module tpu_host_seq #(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tpu_host_seq_if.slave        host,
    output logic                 load_en,
    output logic                 load_sel_ab,
    output logic [1:0]           load_index,
    output logic [7:0]           in_data,
    input  logic                 done,
    output logic                 output_en,
    output logic [1:0]           output_sel,
    input  logic [7:0]           out_data,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {LOAD, WAIT, READ, SEND} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [2:0]      ld_cnt;
    logic [1:0]      rd_cnt;
    logic [1:0]      tx_cnt;
    logic [7:0]      wait_cnt;
    logic [3:0][7:0] buffer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD;
            ld_cnt   <= '0;
            rd_cnt   <= '0;
            tx_cnt   <= '0;
            wait_cnt <= '0;
            buffer   <= '0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    // Every offered byte is taken; ld_cnt wraps to 0 after B3.
                    if (host.s_valid) begin
                        ld_cnt <= ld_cnt + 3'd1;
                        if (ld_cnt == 3'd7) wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    // done wins over a timeout landing on the same edge.
                    if (done) begin
                        rd_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                READ: begin
                    // out_data is combinational from output_sel, so it is
                    // valid for the current rd_cnt by the edge.
                    buffer[rd_cnt] <= out_data;
                    rd_cnt         <= rd_cnt + 2'd1;
                    if (rd_cnt == 2'd3) tx_cnt <= '0;
                end
                SEND: begin
                    if (host.m_ready) tx_cnt <= tx_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        host.s_ready = 1'b0;
        host.m_valid = 1'b0;
        host.m_data  = '0;
        load_en      = 1'b0;
        load_sel_ab  = 1'b0;
        load_index   = '0;
        in_data      = '0;
        output_en    = 1'b0;
        output_sel   = '0;
        busy         = !(state_q == LOAD && ld_cnt == 3'd0);

        case (state_q)
            LOAD: begin
                host.s_ready = 1'b1;
                load_en      = host.s_valid;
                in_data      = host.s_data;
                load_sel_ab  = ld_cnt[2];
                load_index   = ld_cnt[1:0];
                if (host.s_valid && ld_cnt == 3'd7) state_d = WAIT;
            end
            WAIT: begin
                if (done)                        state_d = READ;
                else if (wait_cnt == WAIT_LAST)  state_d = LOAD;
            end
            READ: begin
                // Runs all four reads regardless of done dropping meanwhile.
                output_en  = 1'b1;
                output_sel = rd_cnt;
                if (rd_cnt == 2'd3) state_d = SEND;
            end
            SEND: begin
                host.m_valid = 1'b1;
                host.m_data  = buffer[tx_cnt];
                if (host.m_ready && tx_cnt == 2'd3) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

endmodule

// File: tb/tb_tpu_host_seq.sv
module tb_tpu_host_seq;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    tpu_host_seq_if bus();
    logic       load_en, load_sel_ab;
    logic [1:0] load_index;
    logic [7:0] in_data;
    logic       done, output_en;
    logic [1:0] output_sel;
    logic [7:0] out_data;
    logic       busy, err;
    logic       ctl_done = 1'b0;
    logic       noise_done = 1'b0;

    assign done = ctl_done | noise_done;

    tpu_host_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .host(bus.slave),
        .load_en(load_en), .load_sel_ab(load_sel_ab), .load_index(load_index),
        .in_data(in_data), .done(done), .output_en(output_en),
        .output_sel(output_sel), .out_data(out_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_total = 0;
    int dones_issued = 0;
    int done_cyc = -1;
    int dly = 3;
    bit hang = 1'b0;
    int rdy_mode = 0;
    logic [10:0] load_q[$];
    logic [7:0]  res_q[$];
    logic [7:0]  cmat[8];
    logic [7:0]  cres[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference 2x2 product, low byte: element i of A/B sits at row i/2, col i%2.
    function automatic logic [7:0] mm(input logic [7:0] m[8], input int s);
        int r, c, v;
        r = s / 2;
        c = s % 2;
        v = int'(m[r*2]) * int'(m[4 + c]) + int'(m[r*2 + 1]) * int'(m[6 + c]);
        return v[7:0];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Matrix controller stand-in: captures operand writes, raises done dly
    // cycles after the eighth write, drops it during the first read cycle.
    assign out_data = cres[output_sel];
    initial begin
        int ld_seen, cnt_dn;
        ld_seen = 0;
        cnt_dn = -1;
        for (int i = 0; i < 8; i++) cmat[i] = '0;
        for (int s = 0; s < 4; s++) cres[s] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ld_seen = 0;
                cnt_dn = -1;
                ctl_done = 1'b0;
            end else begin
                if (load_en) begin
                    cmat[{load_sel_ab, load_index}] = in_data;
                    for (int s = 0; s < 4; s++) cres[s] = mm(cmat, s);
                    ld_seen++;
                    if (ld_seen == 8) begin
                        ld_seen = 0;
                        if (!hang) cnt_dn = dly;
                    end
                end else if (cnt_dn > 0) begin
                    cnt_dn--;
                    if (cnt_dn == 0) begin
                        ctl_done = 1'b1;
                        done_cyc = cyc;
                        dones_issued++;
                        cnt_dn = -1;
                    end
                end
                if (ctl_done && output_en) ctl_done = 1'b0;
            end
        end
    end

    // Host receiver: m_ready pattern per transaction.
    initial begin
        int stall_left;
        bit stalled;
        stall_left = 0;
        stalled = 1'b0;
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: bus.m_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!stalled && bus.m_valid && (hs_total % 4) == 1) begin
                        stalled = 1'b1;
                        stall_left = 5;
                    end
                    if (stall_left > 0) begin
                        bus.m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.m_ready = 1'b1;
                    end
                end
                default: bus.m_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit prev_oe, hold_pend, mv_wait;
        int oe_first, oe_len, oe_runs;
        logic [7:0] hold_data, r;
        logic [10:0] e;
        prev_oe = 0; hold_pend = 0; mv_wait = 0;
        oe_first = 0; oe_len = 0; oe_runs = 0; hold_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_oe = 0;
                hold_pend = 0;
                mv_wait = 0;
                continue;
            end
            if (load_en) begin
                if (load_q.size() == 0) begin
                    chk("load_unexpected", 32'(load_en), 32'(0));
                end else begin
                    e = load_q.pop_front();
                    chk("load_sel_idx_data", 32'({load_sel_ab, load_index, in_data}), 32'(e));
                end
            end
            if (!bus.s_ready)
                chk("no_load_outside_load", 32'({load_en, load_sel_ab, load_index, in_data}), 32'(0));
            if (output_en) begin
                if (!prev_oe) begin
                    chk("read_after_done", 32'(dones_issued), 32'(oe_runs + 1));
                    chk("read_latency", 32'(cyc - done_cyc), 32'(1));
                    oe_runs++;
                    oe_first = cyc;
                    oe_len = 0;
                end
                chk("output_sel", 32'(output_sel), 32'(oe_len[1:0]));
                oe_len++;
            end else begin
                if (prev_oe) begin
                    chk("read_length", 32'(oe_len), 32'(4));
                    mv_wait = 1;
                end
                chk("idle_output_sel", 32'(output_sel), 32'(0));
            end
            prev_oe = output_en;
            if (hold_pend) begin
                chk("m_valid_held", 32'(bus.m_valid), 32'(1));
                chk("m_data_stable", 32'(bus.m_data), 32'(hold_data));
                hold_pend = 0;
            end
            if (bus.m_valid) begin
                if (mv_wait) begin
                    chk("m_valid_latency", 32'(cyc - oe_first), 32'(4));
                    mv_wait = 0;
                end
                if (bus.m_ready) begin
                    if (res_q.size() == 0) begin
                        chk("result_unexpected", 32'(bus.m_valid), 32'(0));
                    end else begin
                        r = res_q.pop_front();
                        chk("m_data", 32'(bus.m_data), 32'(r));
                    end
                    hs_total++;
                end else begin
                    hold_pend = 1;
                    hold_data = bus.m_data;
                end
            end else begin
                chk("idle_m_data", 32'(bus.m_data), 32'(0));
            end
        end
    end

    task automatic noise_sv();
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.s_data  = 8'($urandom);
    endtask

    task automatic run_txn(input logic [7:0] b[8], input logic [7:0] exp[4], input int d,
                           input bit hng, input bit nz, input int rmode, input bit exp_err);
        int target, k;
        bit ok;
        logic [2:0] ii;
        dly = d;
        hang = hng;
        rdy_mode = rmode;
        if (!hng) for (int s = 0; s < 4; s++) res_q.push_back(exp[s]);
        target = hs_total + (hng ? 0 : 4);
        for (int i = 0; i < 8; i++) begin
            if (nz) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.s_valid = 1'b0;
                    noise_done = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
            noise_done = nz ? 1'($urandom_range(0, 1)) : 1'b0;
            ii = 3'(i);
            bus.s_valid = 1'b1;
            bus.s_data = b[i];
            load_q.push_back({ii[2], ii[1:0], b[i]});
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            chk("s_ready_in_load", 32'(ok), 32'(1));
            if (i == 0) chk("busy_while_loading", 32'(busy), 32'(1));
        end
        noise_done = 1'b0;
        bus.s_valid = 1'b0;
        k = 0;
        if (hng) begin
            while (!err && k < 40) begin
                if (nz) noise_sv();
                @(posedge clk);
                #1;
                k++;
            end
            bus.s_valid = 1'b0;
            chk("timeout_cycles", 32'(k), 32'(TIMEOUT));
            chk("timeout_s_ready", 32'(bus.s_ready), 32'(1));
            chk("timeout_busy", 32'(busy), 32'(0));
        end else begin
            while (hs_total < target && k < 300) begin
                if (nz) noise_sv();
                @(posedge clk);
                #1;
                k++;
            end
            bus.s_valid = 1'b0;
            chk("txn_results_delivered", 32'(hs_total), 32'(target));
            chk("idle_after_txn", 32'(busy), 32'(0));
        end
        chk("err_flag", 32'(err), 32'(exp_err));
    endtask

    task automatic rand_txn(input bit exp_err);
        logic [7:0] b[8];
        logic [7:0] x[4];
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        for (int s = 0; s < 4; s++) x[s] = mm(b, s);
        run_txn(b, x, $urandom_range(1, 10), 1'b0, 1'b1, 1, exp_err);
    endtask

    initial begin
        logic [7:0] b[8];
        logic [7:0] x[4];
        bit ok;
        logic [2:0] ii;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(bus.s_ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_outs", 32'({load_en, output_en, output_sel, bus.m_valid, bus.m_data}), 32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed stream 01..08 -> 13,16,2B,32; then the same with a 5-cycle stall.
        for (int i = 0; i < 8; i++) b[i] = 8'(i + 1);
        x[0] = 8'h13; x[1] = 8'h16; x[2] = 8'h2B; x[3] = 8'h32;
        run_txn(b, x, 3, 1'b0, 1'b0, 0, 1'b0);
        run_txn(b, x, 2, 1'b0, 1'b0, 2, 1'b0);

        // Controller never answers: timeout, then normal operation with err set.
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        run_txn(b, x, 1, 1'b1, 1'b1, 1, 1'b1);
        repeat (3) rand_txn(1'b1);

        // Reset after five bytes: abandon and restart from A0.
        for (int i = 0; i < 5; i++) begin
            ii = 3'(i);
            bus.s_valid = 1'b1;
            bus.s_data = 8'($urandom);
            load_q.push_back({ii[2], ii[1:0], bus.s_data});
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            chk("partial_s_ready", 32'(ok), 32'(1));
        end
        bus.s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", 32'(bus.s_ready), 32'(1));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_err_cleared", 32'(err), 32'(0));
        chk("midrst_outs", 32'({load_en, output_en, bus.m_valid, load_sel_ab, load_index}), 32'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) rand_txn(1'b0);

        chk("load_queue_drained", 32'(load_q.size()), 32'(0));
        chk("result_queue_drained", 32'(res_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/tpu_host_seq.md
TPU_HOST_SEQ -- requirements
Module: tpu_host_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max cycles to wait for done after the last load before flagging error (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port s_valid  input  1  host byte valid.
REQ-005 SHALL have port s_ready  output  1  host byte accepted when s_valid&&s_ready at clk edge.
REQ-006 SHALL have port s_data  input  8  host byte; order A0,A1,A2,A3,B0,B1,B2,B3.
REQ-007 SHALL have port load_en  output  1  write strobe to matrix controller.
REQ-008 SHALL have port load_sel_ab  output  1  0=A, 1=B.
REQ-009 SHALL have port load_index  output  2  element index.
REQ-010 SHALL have port in_data  output  8  element value.
REQ-011 SHALL have port done  input  1  controller results available.
REQ-012 SHALL have port output_en  output  1  result read enable to controller.
REQ-013 SHALL have port output_sel  output  2  result index (0=c00,1=c01,2=c10,3=c11).
REQ-014 SHALL have port out_data  input  8  selected result low byte, combinational from output_sel.
REQ-015 SHALL have port m_valid  output  1  result byte valid to host.
REQ-016 SHALL have port m_ready  input  1  host accepts result byte.
REQ-017 SHALL have port m_data  output  8  result byte.
REQ-018 SHALL have port busy  output  1  high in any state except LOAD with ld_cnt==0.
REQ-019 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-020 SHALL implement FSM states LOAD, WAIT, READ, SEND; 3-bit ld_cnt, 2-bit rd_cnt, 2-bit tx_cnt, 8-bit wait_cnt, 4x8 result buffer.
REQ-021 LOAD: s_ready=1; load_en=s_valid (combinational, same cycle); in_data=s_data; load_sel_ab=ld_cnt[2]; load_index=ld_cnt[1:0].
REQ-022 LOAD: each accepted byte increments ld_cnt; on 8th accept (ld_cnt==7) go to WAIT, ld_cnt wraps to 0, wait_cnt cleared.
REQ-023 Outside LOAD: s_ready=0, load_en=0, in_data=0, load_sel_ab=0, load_index=0; s_valid ignored.
REQ-024 done while in LOAD, READ or SEND SHALL be ignored.
REQ-025 WAIT: done==1 -> READ next cycle, rd_cnt=0; otherwise wait_cnt++; wait_cnt reaching TIMEOUT-1 with done==0 -> err<=1, go to LOAD.
REQ-026 READ: output_en=1, output_sel=rd_cnt for exactly 4 consecutive cycles; buffer[rd_cnt]<=out_data at each edge; after rd_cnt==3 go to SEND, tx_cnt=0.
REQ-027 READ SHALL complete all 4 reads even if done falls mid-READ.
REQ-028 Outside READ: output_en=0, output_sel=0.
REQ-029 SEND: m_valid=1, m_data=buffer[tx_cnt]; m_data stable while m_valid&&!m_ready; on m_valid&&m_ready tx_cnt++; 4th handshake -> LOAD.
REQ-030 Outside SEND: m_valid=0, m_data=0.
REQ-031 Latency: last load byte accepted at edge N -> WAIT at N; done sampled high at edge M -> first output_en cycle M..M+1; first m_valid 4 cycles after first output_en.
REQ-032 err SHALL clear only on reset; err does not block operation.

Reset
REQ-033 rst_n low SHALL asynchronously force state=LOAD, all counters=0, buffer=0, err=0; all outputs then at REQ-023/028/030 values, s_ready=1, busy=0.
REQ-034 Reset mid-operation SHALL abandon the transaction; the next accepted byte is A0.

Verification
REQ-035 Stream 01,02,03,04,05,06,07,08 with s_valid constant -> load_en 8 cycles, (sel,idx)=(0,0)..(0,3),(1,0)..(1,3), in_data matches.
REQ-036 Model controller: done 3 cycles after last load, out_data per sel = 13,16,2B,32 -> output_en 4 cycles, sel 0..3, m_data 13,16,2B,32 with m_ready=1.
REQ-037 m_ready low 5 cycles at second result -> m_valid held, m_data=16 stable, then 2B,32 follow; no byte lost or repeated.
REQ-038 done never asserted, TIMEOUT=16 -> err=1 16 cycles after WAIT entry, state LOAD, s_ready=1; next transaction succeeds with err still 1.
REQ-039 rst_n pulsed low after 5 bytes loaded -> outputs at reset values immediately; next byte drives load_sel_ab=0, load_index=0.
REQ-040 s_valid high during WAIT/READ/SEND and done high during LOAD -> no load_en, no output_en, s_ready=0 outside LOAD.
